mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
// - MEM-stage consumer of the EX/MEM pipeline register outputs. Turns MemRead/MemWrite + ALU address + store data
//   into a req/ack transaction on the data-memory port; stalls the pipeline until the access completes.
// - Sits between the EX/MEM register and the MEM/WB register; RdData_o feeds the MEM/WB load-data input.
// PARAMETERS
// - TIMEOUT_CYC  16  max BUSY cycles waiting for mem_ack_i before aborting with err_o
// PORTS
// - clk_i          in   1   clock, rising edge
// - rst_n_i        in   1   reset, asynchronous, active-low
// - MemRead_i      in   1   load request (from EX/MEM)
// - MemWrite_i     in   1   store request (from EX/MEM)
// - Addr_i         in   32  byte address = ALU_Result (from EX/MEM)
// - WrData_i       in   32  store data = MemWrite_Data (from EX/MEM)
// - stall_o        out  1   hold PC, IF/ID, ID/EX, EX/MEM (their start_i = ~stall_o)
// - RdData_o       out  32  load data, valid while rd_valid_o
// - rd_valid_o     out  1   load completed this cycle
// - err_o          out  1   access aborted this cycle (misaligned or timeout)
// - mem_req_o      out  1   memory request
// - mem_we_o       out  1   1 = write, 0 = read
// - mem_addr_o     out  32  word-aligned memory address
// - mem_wdata_o    out  32  write data
// - mem_ack_i      in   1   memory completion, 1-cycle pulse
// - mem_rdata_i    in   32  read data, valid with mem_ack_i
// BEHAVIOUR
// - Reset (rst_n_i low, async): state=IDLE, timeout counter=0.
//   - All registered outputs are 0: RdData_o, rd_valid_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o.
//   - stall_o is forced to 0 while rst_n_i is low.
// - access = MemRead_i | MemWrite_i. If both are set, the access is a write (MemWrite_i wins).
// - FSM: IDLE, BUSY, DONE.
// - IDLE
//   - stall_o = access (combinational).
//   - Aligned access (Addr_i[1:0]==0):
//     - Register mem_addr_o=Addr_i, mem_wdata_o=WrData_i, mem_we_o=MemWrite_i, mem_req_o=1; counter=0.
//     - Go to BUSY.
//   - Misaligned access: no memory request is issued; go to DONE with error flag set.
//   - No access: stay in IDLE.
// - BUSY
//   - stall_o=1. mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable.
//   - mem_ack_i=1:
//     - Drop mem_req_o.
//     - If read, RdData_o <= mem_rdata_i.
//     - Go to DONE.
//   - No ack: counter++. When the counter reaches TIMEOUT_CYC-1 without an ack:
//     - Drop mem_req_o, RdData_o <= 0, set error flag, go to DONE.
//   - An ack in the same cycle as the timeout limit counts as success; the ack wins.
// - DONE (exactly 1 cycle)
//   - stall_o=0, so the pipeline advances at the end of this cycle.
//   - Access inputs are ignored; they still hold the completed instruction.
//   - rd_valid_o=1 only for a successful read. err_o=1 only for an abort.
//   - Always go to IDLE.
// - Latency (aligned access, ack in cycle k after entry to BUSY at cycle 1): stall_o high cycles 0..k, DONE at k+1.
//   - Minimum total is 3 cycles: IDLE, BUSY, DONE.
// - rd_valid_o and err_o are 1-cycle pulses, never both high. mem_ack_i outside BUSY is ignored.
// - Reset mid-BUSY: mem_req_o drops immediately (async); the in-flight access is abandoned and no response follows.
// TESTING
// - Read at 0x0000_0010, ack on 2nd BUSY cycle with rdata 0xCAFE_F00D:
//   - stall_o high 3 cycles; DONE: rd_valid_o=1, RdData_o=0xCAFE_F00D.
// - Write 0x1234_5678 to 0x40, ack on 1st BUSY cycle:
//   - mem_we_o=1, mem_addr_o=0x40, mem_wdata_o=0x1234_5678 stable while req.
//   - DONE: rd_valid_o=0, err_o=0; 3-cycle access.
// - Read at 0x0000_0013:
//   - mem_req_o never asserts; 1 stall cycle, then DONE with err_o=1, rd_valid_o=0.
// - Read, no ack:
//   - mem_req_o drops after TIMEOUT_CYC BUSY cycles; DONE err_o=1, RdData_o=0.
//   - Also check: ack on the limit cycle gives rd_valid_o=1.
// - Back-to-back loads held by stall:
//   - Second load issues in the cycle after DONE; exactly 2 requests total, none duplicated.
// - rst_n_i low during BUSY:
//   - mem_req_o=0 and stall_o=0 immediately.
//   - After release, IDLE with all outputs 0; a late mem_ack_i is ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory sequencer: turns EX/MEM load/store requests into a req/ack
// transaction and holds the pipeline until the access completes, times out or is rejected.
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WrData_i,
  output logic        stall_o,
  output logic [31:0] RdData_o,
  output logic        rd_valid_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             err_q, err_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             access;
  logic             aligned;
  logic             stall;

  assign access  = MemRead_i | MemWrite_i;
  assign aligned = (Addr_i[1:0] == 2'b00);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // rd_valid/err are one-cycle pulses that exist only while in DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    stall      = 1'b0;

    case (state_q)
      IDLE: begin
        stall = access;
        if (access) begin
          if (aligned) begin
            addr_d  = Addr_i;
            wdata_d = WrData_i;
            we_d    = MemWrite_i;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        // An ack arriving on the limit cycle still completes the access.
        if (mem_ack_i) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            rd_data_d  = mem_rdata_i;
            rd_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_MAX) begin
          req_d     = 1'b0;
          rd_data_d = '0;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall_o     = rst_n_i & stall;
  assign RdData_o    = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign err_o       = err_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule
